// File: rtl/soc_system_pio_pkg.sv
// Shared register map and mode encodings for the soc_system PIO block.
// Constants only: no latency, no backpressure.
package soc_system_pio_pkg;

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_DIR    = 3'd1;
    localparam logic [2:0] ADDR_MASK   = 3'd2;
    localparam logic [2:0] ADDR_EDGE   = 3'd3;
    localparam logic [2:0] ADDR_OUTSET = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR = 3'd5;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    localparam int IRQ_LEVEL = 0;
    localparam int IRQ_EDGE  = 1;

endpackage

// File: rtl/pio_sync_edge.sv
// Input synchroniser plus edge detector; sync_in lags in_port by SYNC_STAGES cycles,
// edge_detect is combinational from the last two flops. No backpressure.
module pio_sync_edge
    import soc_system_pio_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_ANY
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [DATA_WIDTH-1:0] sync_in,
    output logic [DATA_WIDTH-1:0] edge_detect
);

    logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [DATA_WIDTH-1:0] prev_in;
    logic [SYNC_STAGES:0]  primed;
    logic [DATA_WIDTH-1:0] rise;
    logic [DATA_WIDTH-1:0] fall;
    logic [DATA_WIDTH-1:0] edge_sel;

    // primed holds off detection until the chain and prev_in have refilled after
    // reset, so an input already high at reset release is not seen as an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_in <= '0;
            primed  <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_in <= sync_q[SYNC_STAGES-1];
            primed  <= {primed[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign sync_in = sync_q[SYNC_STAGES-1];
    assign rise    = sync_in & ~prev_in;
    assign fall    = ~sync_in & prev_in;

    always_comb begin
        edge_sel = rise | fall;
        if (EDGE_TYPE == EDGE_RISE) begin
            edge_sel = rise;
        end else if (EDGE_TYPE == EDGE_FALL) begin
            edge_sel = fall;
        end
    end

    assign edge_detect = primed[SYNC_STAGES] ? edge_sel : '0;

endmodule

// File: rtl/soc_system_pio_irq.sv
// Avalon-MM parallel I/O slave with direction, edge capture and masked IRQ.
// Read data registered one cycle after address, writes take effect on the sampling edge; no wait states.
module soc_system_pio_irq
    import soc_system_pio_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    SYNC_STAGES = 2,
    parameter int                    EDGE_TYPE   = EDGE_ANY,
    parameter int                    IRQ_TYPE    = IRQ_EDGE,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic [DATA_WIDTH-1:0] out_oe,
    output logic                  irq
);

    logic                  wr;
    logic [DATA_WIDTH-1:0] wd;
    logic [DATA_WIDTH-1:0] data_out;
    logic [DATA_WIDTH-1:0] dir;
    logic [DATA_WIDTH-1:0] irq_mask;
    logic [DATA_WIDTH-1:0] edge_capture;
    logic [DATA_WIDTH-1:0] edge_clr;
    logic [DATA_WIDTH-1:0] sync_in;
    logic [DATA_WIDTH-1:0] edge_detect;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [31:0]           rd_ext;

    pio_sync_edge #(
        .DATA_WIDTH  (DATA_WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync_edge (
        .clk         (clk),
        .reset       (reset),
        .in_port     (in_port),
        .sync_in     (sync_in),
        .edge_detect (edge_detect)
    );

    assign wr = chipselect & ~write_n;
    assign wd = writedata[DATA_WIDTH-1:0];

    generate
        if (DATA_WIDTH < 32) begin : g_unused_wd
            logic unused_wd_hi;
            assign unused_wd_hi = ^writedata[31:DATA_WIDTH];
        end
    endgenerate

    assign edge_clr = (wr && address == ADDR_EDGE) ? wd : '0;

    always_comb begin
        rd_word = '0;
        case (address)
            ADDR_DATA:   rd_word = (sync_in & ~dir) | (data_out & dir);
            ADDR_DIR:    rd_word = dir;
            ADDR_MASK:   rd_word = irq_mask;
            ADDR_EDGE:   rd_word = edge_capture;
            ADDR_OUTSET: rd_word = data_out;
            ADDR_OUTCLR: rd_word = data_out;
            default:     rd_word = '0;
        endcase
        rd_ext = '0;
        rd_ext[DATA_WIDTH-1:0] = rd_word;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out     <= RESET_VALUE;
            dir          <= '0;
            irq_mask     <= '0;
            edge_capture <= '0;
            readdata     <= '0;
        end else begin
            if (wr) begin
                case (address)
                    ADDR_DATA:   data_out <= wd;
                    ADDR_DIR:    dir      <= wd;
                    ADDR_MASK:   irq_mask <= wd;
                    ADDR_OUTSET: data_out <= data_out | wd;
                    ADDR_OUTCLR: data_out <= data_out & ~wd;
                    default:     ;
                endcase
            end
            // OR-ing the new edge after the clear lets a same-cycle edge win.
            edge_capture <= (edge_capture & ~edge_clr) | edge_detect;
            readdata     <= rd_ext;
        end
    end

    assign out_port = data_out;
    assign out_oe   = dir;

    generate
        if (IRQ_TYPE == IRQ_EDGE) begin : g_irq_edge
            assign irq = |(edge_capture & irq_mask);
        end else begin : g_irq_level
            assign irq = |(sync_in & irq_mask);
        end
    endgenerate

endmodule

// File: tb/tb_soc_system_pio_irq.sv
// Directed bench for soc_system_pio_irq: a rising-edge and an any-edge instance share one bus.
module tb_soc_system_pio_irq;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [2:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [DW-1:0] in_port;
    logic [31:0]   readdata0, readdata2;
    logic [DW-1:0] out_port0, out_port2;
    logic [DW-1:0] out_oe0, out_oe2;
    logic          irq0, irq2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          sel;
        logic [31:0] exp;
        string       tag;
    } rd_exp_t;

    rd_exp_t sb [$];

    always #5 clk = ~clk;

    soc_system_pio_irq #(
        .DATA_WIDTH (DW), .SYNC_STAGES (2), .EDGE_TYPE (0), .IRQ_TYPE (1), .RESET_VALUE (8'hA5)
    ) dut0 (
        .clk (clk), .reset (reset), .address (address), .chipselect (chipselect),
        .write_n (write_n), .writedata (writedata), .readdata (readdata0),
        .in_port (in_port), .out_port (out_port0), .out_oe (out_oe0), .irq (irq0)
    );

    soc_system_pio_irq #(
        .DATA_WIDTH (DW), .SYNC_STAGES (2), .EDGE_TYPE (2), .IRQ_TYPE (1), .RESET_VALUE (8'hA5)
    ) dut2 (
        .clk (clk), .reset (reset), .address (address), .chipselect (chipselect),
        .write_n (write_n), .writedata (writedata), .readdata (readdata2),
        .in_port (in_port), .out_port (out_port2), .out_oe (out_oe2), .irq (irq2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input int sel, input logic [2:0] a, input logic [31:0] exp,
                            input string tag);
        rd_exp_t e;
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        sb.push_back('{sel: sel, exp: exp, tag: tag});
        tick(1);
        chipselect = 1'b0;
        e = sb.pop_front();
        check(e.tag, (e.sel == 2) ? readdata2 : readdata0, e.exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rst_rd [8];
        rst_rd = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hA5, 32'hA5, 32'h0, 32'h0};

        reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1;
        writedata = '0; in_port = '0;
        tick(3);
        reset = 1'b0;
        tick(5);

        // Reset state
        for (int i = 0; i < 8; i++) begin
            bus_read(0, 3'(i), rst_rd[i], $sformatf("reset_rd_addr%0d", i));
        end
        check("reset_irq", {31'd0, irq0}, 32'd0);
        check("reset_out_oe", {24'd0, out_oe0}, 32'd0);
        check("reset_out_port", {24'd0, out_port2}, 32'hA5);

        // Data, set and clear; upper writedata bits are dropped
        bus_write(3'd1, 32'h0000_00FF);
        check("dir_out_oe", {24'd0, out_oe2}, 32'hFF);
        bus_write(3'd0, 32'hABCD_EF0F);
        check("data_wr", {24'd0, out_port0}, 32'h0F);
        bus_read(0, 3'd0, 32'h0000_000F, "data_rd_upper_zero");
        bus_write(3'd4, 32'h30);
        check("outset", {24'd0, out_port0}, 32'h3F);
        bus_write(3'd5, 32'h03);
        check("outclr", {24'd0, out_port0}, 32'h3C);
        bus_read(0, 3'd0, 32'h3C, "data_rd_dir_out");
        bus_read(0, 3'd5, 32'h3C, "outclr_rd");
        bus_write(3'd1, 32'h0);

        // Rising-edge capture latency on bit 0
        bus_write(3'd2, 32'h1);
        in_port = 8'h01;
        tick(1);
        check("edge_lat_1", {31'd0, irq0}, 32'd0);
        tick(1);
        check("edge_lat_2", {31'd0, irq0}, 32'd0);
        tick(1);
        check("edge_lat_3", {31'd0, irq0}, 32'd1);
        bus_read(0, 3'd3, 32'h01, "edge_cap_rise");
        bus_write(3'd3, 32'h1);
        check("clr_irq", {31'd0, irq0}, 32'd0);
        in_port = 8'h00;
        tick(5);
        bus_read(0, 3'd3, 32'h00, "no_cap_on_fall");
        check("no_irq_on_fall", {31'd0, irq0}, 32'd0);

        // Clear coinciding with a new edge: the edge wins
        in_port = 8'h01;
        tick(2);
        bus_write(3'd3, 32'h1);
        check("set_wins_irq", {31'd0, irq0}, 32'd1);
        bus_read(0, 3'd3, 32'h01, "set_wins_cap");
        bus_write(3'd3, 32'h1);
        check("clear_again_irq", {31'd0, irq0}, 32'd0);
        bus_read(0, 3'd3, 32'h00, "clear_again_cap");

        // Any-edge capture with masking on bit 5
        bus_write(3'd2, 32'h0);
        bus_write(3'd3, 32'hFF);
        in_port = 8'h21;
        tick(4);
        in_port = 8'h01;
        tick(4);
        bus_read(2, 3'd3, 32'h20, "any_edge_cap");
        check("masked_irq", {31'd0, irq2}, 32'd0);
        bus_write(3'd2, 32'h20);
        check("unmask_irq", {31'd0, irq2}, 32'd1);
        bus_write(3'd2, 32'h0);
        check("remask_irq", {31'd0, irq2}, 32'd0);
        bus_read(2, 3'd3, 32'h20, "remask_cap_kept");

        // Reset while bit 3 is inside the synchroniser
        in_port = 8'h00;
        tick(5);
        bus_write(3'd3, 32'hFF);
        in_port = 8'h08;
        tick(1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("midrst_out_port", {24'd0, out_port0}, 32'hA5);
        check("midrst_out_oe", {24'd0, out_oe0}, 32'h00);
        tick(6);
        bus_read(0, 3'd3, 32'h00, "midrst_cap_rise");
        bus_read(2, 3'd3, 32'h00, "midrst_cap_any");
        bus_read(0, 3'd0, 32'h08, "midrst_sync_in");
        bus_write(3'd2, 32'hFF);
        check("midrst_irq_rise", {31'd0, irq0}, 32'd0);
        check("midrst_irq_any", {31'd0, irq2}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
